// File: rtl/pc_pkg.sv
// Shared encodings for the PC fetch stage: core sequencing states and
// the next-PC source select codes used by next_pc_mux.
package pc_pkg;

    // Fetch-stage sequencing states
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } pcState_t;

    // Next-PC source select
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_SEQ  = 2'd1,
        SEL_BR   = 2'd2,
        SEL_JMP  = 2'd3
    } nextPcSel_t;

    // Priority: stall and halt both hold the PC, then jump, then branch, then sequential
    function automatic nextPcSel_t selectNextPc(
        input logic stall,
        input logic halt,
        input logic jump,
        input logic branchTaken
    );
        if (stall || halt) begin
            return SEL_HOLD;
        end else if (jump) begin
            return SEL_JMP;
        end else if (branchTaken) begin
            return SEL_BR;
        end
        return SEL_SEQ;
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection: builds pc+1, the jump target
// (upper bits of pc+1 concatenated with the instruction jump field) and
// picks the highest-priority source. Assumes JUMP_W < WIDTH.
module next_pc_mux
    import pc_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int JUMP_W = 26
) (
    input  logic [WIDTH-1:0]  pc,
    input  logic              stall,
    input  logic              halt,
    input  logic              jump,
    input  logic              branchTaken,
    input  logic [WIDTH-1:0]  pcBranch,
    input  logic [JUMP_W-1:0] jumpTarget,
    output logic [WIDTH-1:0]  pcPlus1,
    output logic [WIDTH-1:0]  nextPc,
    output nextPcSel_t        sel
);

    logic [WIDTH-1:0] jumpPc;

    assign pcPlus1 = pc + {{(WIDTH-1){1'b0}}, 1'b1};
    assign jumpPc  = {pcPlus1[WIDTH-1:JUMP_W], jumpTarget};
    assign sel     = selectNextPc(stall, halt, jump, branchTaken);

    // Route the selected source; hold reflects the current PC back
    always_comb begin
        nextPc = pc;
        case (sel)
            SEL_SEQ:  nextPc = pcPlus1;
            SEL_BR:   nextPc = pcBranch;
            SEL_JMP:  nextPc = jumpPc;
            default:  nextPc = pc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: state register (BOOT/RUN/HALT/FAULT), PC
// register, fetch counter and optional instruction-memory bound check.
// Optional feature: define PC_BOUND_CHECK_EN to trap next PCs >= IMEM_DEPTH
// into the sticky FAULT state; without it the PC wraps freely and fault=0.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int               JUMP_W     = 26,
    parameter int               IMEM_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [WIDTH-1:0]  pc_branch_in,
    input  logic              jump,
    input  logic [JUMP_W-1:0] jump_target,
    input  logic              halt,
    output logic [WIDTH-1:0]  pc_out,
    output logic [WIDTH-1:0]  pc_plus1_out,
    output logic              fetch_valid,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       fetch_count
);

    pcState_t         state;
    pcState_t         stateNext;
    logic [WIDTH-1:0] pcReg;
    logic [WIDTH-1:0] pcNext;
    logic [31:0]      countReg;
    logic [31:0]      countNext;
    logic [WIDTH-1:0] muxNextPc;
    nextPcSel_t       muxSel;
    logic             outOfRange;

    next_pc_mux #(
        .WIDTH (WIDTH),
        .JUMP_W(JUMP_W)
    ) uNextPcMux (
        .pc         (pcReg),
        .stall      (stall),
        .halt       (halt),
        .jump       (jump),
        .branchTaken(branch_taken),
        .pcBranch   (pc_branch_in),
        .jumpTarget (jump_target),
        .pcPlus1    (pc_plus1_out),
        .nextPc     (muxNextPc),
        .sel        (muxSel)
    );

`ifdef PC_BOUND_CHECK_EN
    localparam logic [WIDTH-1:0] IMEM_LIMIT = WIDTH'(IMEM_DEPTH);
    assign outOfRange = (muxNextPc >= IMEM_LIMIT);
    assign fault      = (state == FAULT);
`else
    logic unusedImemDepth;
    assign unusedImemDepth = (IMEM_DEPTH != 0);
    assign outOfRange      = 1'b0;
    assign fault           = 1'b0;
`endif

    // State, PC and counter registers; reset is asynchronous and overrides any state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            pcReg    <= RESET_PC;
            countReg <= '0;
        end else begin
            state    <= stateNext;
            pcReg    <= pcNext;
            countReg <= countNext;
        end
    end

    // Sequencing: inputs only matter in RUN; HALT and FAULT freeze everything
    always_comb begin
        stateNext = state;
        pcNext    = pcReg;
        countNext = countReg;
        case (state)
            BOOT: stateNext = RUN;
            RUN: begin
                if (muxSel == SEL_HOLD) begin
                    // halt during stall is ignored and re-sampled once stall drops
                    if (halt && !stall) begin
                        stateNext = HALT;
                    end
                end else if (outOfRange) begin
                    stateNext = FAULT;
                end else begin
                    pcNext    = muxNextPc;
                    countNext = countReg + 32'd1;
                end
            end
            HALT:    stateNext = HALT;
            FAULT:   stateNext = FAULT;
            default: stateNext = BOOT;
        endcase
    end

    assign pc_out      = pcReg;
    assign fetch_count = countReg;
    assign fetch_valid = (state == RUN) && !stall;
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// randomized control traffic compared against a behavioural model.
module tb_pc_fetch_unit;

`ifdef PC_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif
    localparam int IMEM_DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] pcBranch = '0;
    logic        jump = 1'b0;
    logic [25:0] jumpTarget = '0;
    logic        halt = 1'b0;

    logic [31:0] pcOut, pcPlus1, fetchCount;
    logic        fetchValid, halted, fault;
    logic [31:0] wPcOut, wPcPlus1, wFetchCount;
    logic        wFetchValid, wHalted, wFault;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mPc;
    logic [31:0] mCount;
    bit          mBooted, mHalted, mFaulted;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .WIDTH(32), .RESET_PC(32'd0), .JUMP_W(26), .IMEM_DEPTH(IMEM_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branchTaken),
        .pc_branch_in(pcBranch), .jump(jump), .jump_target(jumpTarget), .halt(halt),
        .pc_out(pcOut), .pc_plus1_out(pcPlus1), .fetch_valid(fetchValid),
        .halted(halted), .fault(fault), .fetch_count(fetchCount)
    );

    // Second instance preloaded at the top of the address space to exercise wrap
    pc_fetch_unit #(
        .WIDTH(32), .RESET_PC(32'hFFFF_FFFF), .JUMP_W(26), .IMEM_DEPTH(IMEM_DEPTH)
    ) dutWrap (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branchTaken),
        .pc_branch_in(pcBranch), .jump(jump), .jump_target(jumpTarget), .halt(halt),
        .pc_out(wPcOut), .pc_plus1_out(wPcPlus1), .fetch_valid(wFetchValid),
        .halted(wHalted), .fault(wFault), .fetch_count(wFetchCount)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        stall = 1'b0; halt = 1'b0; jump = 1'b0; branchTaken = 1'b0;
        pcBranch = '0; jumpTarget = '0;
    endtask

    function automatic void modelReset();
        mPc = 32'd0; mCount = 32'd0;
        mBooted = 1'b0; mHalted = 1'b0; mFaulted = 1'b0;
    endfunction

    // One clock of the architectural rules, evaluated from the current inputs
    function automatic void modelStep();
        logic [31:0] target;
        if (!mBooted) begin
            mBooted = 1'b1;
        end else if (!mHalted && !mFaulted && !stall) begin
            if (halt) begin
                mHalted = 1'b1;
            end else begin
                if (jump)
                    target = ((mPc + 32'd1) & ~32'h03FF_FFFF) | {6'd0, jumpTarget};
                else if (branchTaken)
                    target = pcBranch;
                else
                    target = mPc + 32'd1;
                if (BOUND_EN && target >= IMEM_DEPTH) begin
                    mFaulted = 1'b1;
                end else begin
                    mPc = target;
                    mCount = mCount + 32'd1;
                end
            end
        end
    endfunction

    // Compare all outputs mid-cycle, then advance one edge alongside the model
    task automatic cycle();
        @(negedge clk);
        checkEq("pc", pcOut, mPc);
        checkEq("pc_plus1", pcPlus1, mPc + 32'd1);
        checkEq("fetch_valid", {31'd0, fetchValid},
                {31'd0, mBooted && !mHalted && !mFaulted && !stall});
        checkEq("halted", {31'd0, halted}, {31'd0, mHalted});
        checkEq("fault", {31'd0, fault}, {31'd0, mFaulted});
        checkEq("fetch_count", fetchCount, mCount);
        @(posedge clk);
        modelStep();
        #1;
    endtask

    // Asynchronous reset pulse asserted between edges; effect checked before any edge
    task automatic doReset();
        reset = 1'b1;
        clearInputs();
        modelReset();
        #2;
        checkEq("rst_pc", pcOut, 32'd0);
        checkEq("rst_fault", {31'd0, fault}, 32'd0);
        checkEq("rst_halted", {31'd0, halted}, 32'd0);
        checkEq("rst_count", fetchCount, 32'd0);
        checkEq("rst_fv", {31'd0, fetchValid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] heldCount;
        modelReset();
        @(posedge clk);
        #1;

        // Boot then sequential fetch; wrap instance checked alongside
        doReset();
        checkEq("wrap_boot_pc", wPcOut, 32'hFFFF_FFFF);
        checkEq("wrap_boot_plus1", wPcPlus1, 32'd0);
        cycle();
        checkEq("wrap_run_pc", wPcOut, 32'hFFFF_FFFF);
        checkEq("wrap_run_plus1", wPcPlus1, 32'd0);
        cycle();
        checkEq("wrap_pc_zero", wPcOut, 32'd0);
        cycle();
        cycle();
        checkEq("seq_pc3", pcOut, 32'd3);
        checkEq("seq_count3", fetchCount, 32'd3);

        // Branch then jump-over-branch
        cycle();
        cycle();
        checkEq("at_pc5", pcOut, 32'd5);
        branchTaken = 1'b1; pcBranch = 32'd20;
        cycle();
        checkEq("branch_pc", pcOut, 32'd20);
        jump = 1'b1; jumpTarget = 26'd7;
        cycle();
        checkEq("jump_wins_pc", pcOut, 32'd7);
        clearInputs();
        cycle();
        cycle();
        checkEq("at_pc9", pcOut, 32'd9);

        // Stall with halt in the middle, then a real halt
        heldCount = fetchCount;
        stall = 1'b1;
        cycle();
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        cycle();
        checkEq("stall_pc", pcOut, 32'd9);
        checkEq("stall_count", fetchCount, heldCount);
        checkEq("stall_nohalt", {31'd0, halted}, 32'd0);
        stall = 1'b0; halt = 1'b1;
        cycle();
        checkEq("halt_taken", {31'd0, halted}, 32'd1);
        halt = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        checkEq("halt_pc", pcOut, 32'd9);

        // Branch just past the memory bound, then reset mid-state
        doReset();
        cycle();
        branchTaken = 1'b1; pcBranch = 32'd64;
        cycle();
        clearInputs();
        checkEq("bound_pc", pcOut, BOUND_EN ? 32'd0 : 32'd64);
        checkEq("bound_fault", {31'd0, fault}, {31'd0, BOUND_EN});
        cycle();
        cycle();
        doReset();

        // Randomized control traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(99) < 2) begin
                doReset();
            end else begin
                stall       = ($urandom_range(99) < 20);
                halt        = ($urandom_range(99) < 2);
                jump        = ($urandom_range(99) < 10);
                branchTaken = ($urandom_range(99) < 25);
                pcBranch    = ($urandom_range(99) < 3) ? $urandom : 32'($urandom_range(70));
                jumpTarget  = 26'($urandom_range(70));
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
